// File: rtl/seq_playback_pkg.sv
// seq_playback_pkg: shared game types, the blank symbol and small constant helpers.
package seq_playback_pkg;
    localparam int SYM_W = 4;
    localparam logic [SYM_W-1:0] BLANK_SYM = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW    = 2'd1,
        GAP     = 2'd2,
        HANDOFF = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/seq_playback_if.sv
// seq_playback_if: control, storage-write and display signals of the playback block.
interface seq_playback_if #(
    parameter int IDX_W = 3,
    parameter int SYM_W = seq_playback_pkg::SYM_W
) ();
    import seq_playback_pkg::*;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [SYM_W-1:0] wr_data;
    logic [IDX_W:0]   len;
    logic             start;
    logic             abort;
    logic [SYM_W-1:0] symbol;
    logic             sym_valid;
    logic [IDX_W-1:0] index;
    logic             busy;
    logic             done;
    logic             allow;
    logic             err;

    modport master (
        output wr_en, wr_addr, wr_data, len, start, abort,
        input  symbol, sym_valid, index, busy, done, allow, err
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, len, start, abort,
        output symbol, sym_valid, index, busy, done, allow, err
    );
endinterface

// File: rtl/seq_playback_tick_timer.sv
// seq_playback_tick_timer: counts enabled cycles and pulses expire on the load-th one.
module seq_playback_tick_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] load,
    output logic         expire
);
    logic [W-1:0] cnt;

    assign expire = en && cnt == load - W'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (clr || expire) ? '0 : en ? cnt + W'(1) : cnt;
endmodule

// File: rtl/seq_playback.sv
// seq_playback: stores the target symbol sequence and plays it out with show/gap timing,
// then opens the player-input window (allow) until the next start or abort.
module seq_playback #(
    parameter int SEQ_LEN   = 8,
    parameter int IDX_W     = 3,
    parameter int SYM_W     = seq_playback_pkg::SYM_W,
    parameter int ON_TICKS  = 50,
    parameter int GAP_TICKS = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_playback_if.slave bus
);
    import seq_playback_pkg::*;

    localparam int TW = $clog2(max2(ON_TICKS, GAP_TICKS) + 1);

    state_t           state, state_nx;
    logic [SYM_W-1:0] mem [SEQ_LEN];
    logic [IDX_W-1:0] idx, idx_nx;
    logic [IDX_W:0]   len_q, len_nx;
    logic             done_q, err_q, expire, can_start, len_ok, go, last;

    assign can_start = state == IDLE || state == HANDOFF;
    assign len_ok    = bus.len != '0 && bus.len <= (IDX_W+1)'(SEQ_LEN);
    assign go        = can_start && bus.start && !bus.abort;
    assign last      = (IDX_W+1)'(idx) == len_q - (IDX_W+1)'(1);

    seq_playback_tick_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_nx != state),
        .en     (bus.busy),
        .load   (state == SHOW ? TW'(ON_TICKS) : TW'(GAP_TICKS)),
        .expire (expire)
    );

    // abort outranks start and timer expiry
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        len_nx   = len_q;
        if (bus.abort) begin
            state_nx = IDLE;
            idx_nx   = '0;
        end else if (go && len_ok) begin
            state_nx = SHOW;
            idx_nx   = '0;
            len_nx   = bus.len;
        end else if (state == SHOW && expire) begin
            state_nx = GAP;
        end else if (state == GAP && expire) begin
            state_nx = last ? HANDOFF : SHOW;
            idx_nx   = last ? idx : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            len_q  <= len_nx;
            done_q <= state != HANDOFF && state_nx == HANDOFF;
            err_q  <= go && !len_ok;
        end

    // writes are locked out while playing so the shown sequence cannot change
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < SEQ_LEN; i++) mem[i] <= '0;
        end else if (bus.wr_en && can_start) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end

    assign bus.busy      = state == SHOW || state == GAP;
    assign bus.sym_valid = state == SHOW;
    assign bus.symbol    = bus.sym_valid ? mem[idx] : BLANK_SYM;
    assign bus.index     = bus.busy ? idx : '0;
    assign bus.allow     = state == HANDOFF;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_playback.sv
// tb_seq_playback: directed scenarios for seq_playback with ON_TICKS=3, GAP_TICKS=2.
module tb_seq_playback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [12:0] obs;

    seq_playback_if #(.IDX_W(3), .SYM_W(4)) bus ();

    seq_playback #(
        .SEQ_LEN(8), .IDX_W(3), .SYM_W(4), .ON_TICKS(3), .GAP_TICKS(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.symbol, bus.sym_valid, bus.index, bus.busy, bus.done, bus.allow, bus.err};

    // packs expected outputs in the same order as obs
    function automatic logic [12:0] mk(input logic [3:0] s, input logic v, input logic [2:0] k,
                                       input logic b, input logic d, input logic a, input logic e);
        return {s, v, k, b, d, a, e};
    endfunction

    task automatic do_write(input logic [2:0] a, input logic [3:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] l);
        bus.start = 1'b1; bus.len = l;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        n_chk++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL abort_to_idle: got %h want %h", obs, 13'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        do_write(3'd0, 4'h7);
        pulse_start(4'd2);
        @(negedge clk);
        n_chk++;
        if (obs !== mk(4'h7, 1, 0, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_pre_show: got %h want %h", obs, mk(4'h7, 1, 0, 1, 0, 0, 0));
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_async_clear: got %h want %h", obs, 13'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", obs, 13'h0);
        end
        @(posedge clk); #1;
        pulse_start(4'd8);
        for (int i = 0; i < 42; i++) begin
            e = i < 40 ? mk(4'h0, (i % 5) < 3, 3'(i / 5), 1, 0, 0, 0)
                       : mk(4'h0, 0, 0, 0, i == 40, 1, 0);
            @(negedge clk);
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mem_zero cycle %0d: got %h want %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
        pulse_abort();
    endtask

    task automatic test_play();
        logic [3:0] m [3] = '{4'h5, 4'hA, 4'h3};
        logic [12:0] e;
        do_write(3'd0, 4'h5);
        do_write(3'd1, 4'hA);
        do_write(3'd2, 4'h3);
        pulse_start(4'd3);
        for (int i = 0; i < 18; i++) begin
            e = i < 15 ? mk((i % 5) < 3 ? m[i / 5] : 4'h0, (i % 5) < 3, 3'(i / 5), 1, 0, 0, 0)
                       : mk(4'h0, 0, 0, 0, i == 15, 1, 0);
            @(negedge clk);
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL play cycle %0d: got %h want %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
        pulse_abort();
    endtask

    task automatic test_err();
        logic [3:0] bad [2] = '{4'd0, 4'd9};
        for (int j = 0; j < 2; j++) begin
            pulse_start(bad[j]);
            @(negedge clk);
            n_chk++;
            if (obs !== mk(0, 0, 0, 0, 0, 0, 1)) begin
                n_fail++;
                $display("FAIL err_pulse len=%0d: got %h want %h", bad[j], obs, mk(0, 0, 0, 0, 0, 0, 1));
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_chk++;
            if (obs !== 13'h0) begin
                n_fail++;
                $display("FAIL err_stays_idle len=%0d: got %h want %h", bad[j], obs, 13'h0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        pulse_start(4'd3);
        repeat (6) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs !== mk(4'hA, 1, 1, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL abort_pre: got %h want %h", obs, mk(4'hA, 1, 1, 1, 0, 0, 0));
        end
        @(posedge clk); #1;
        bus.abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== 13'h0) begin
                n_fail++;
                $display("FAIL abort_idle cycle %0d: got %h want %h", i, obs, 13'h0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wr_ignore();
        logic [3:0] m [3] = '{4'h5, 4'hA, 4'h3};
        logic [12:0] e;
        pulse_start(4'd3);
        for (int i = 0; i < 17; i++) begin
            bus.wr_en = i == 3; bus.wr_addr = 3'd1; bus.wr_data = 4'hF;
            e = i < 15 ? mk((i % 5) < 3 ? m[i / 5] : 4'h0, (i % 5) < 3, 3'(i / 5), 1, 0, 0, 0)
                       : mk(4'h0, 0, 0, 0, i == 15, 1, 0);
            @(negedge clk);
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL wr_ignore cycle %0d: got %h want %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_handoff_restart();
        logic [12:0] e;
        bus.start = 1'b1; bus.len = 4'd1;
        @(negedge clk);
        n_chk++;
        if (obs !== mk(0, 0, 0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL restart_pre: got %h want %h", obs, mk(0, 0, 0, 0, 0, 1, 0));
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            e = i < 5 ? mk(i < 3 ? 4'h5 : 4'h0, i < 3, 0, 1, 0, 0, 0)
                      : mk(4'h0, 0, 0, 0, i == 5, 1, 0);
            @(negedge clk);
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL restart cycle %0d: got %h want %h", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'h9;
        bus.start = 1'b1; bus.len = 4'd1;
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (obs !== mk(4'h9, 1, 0, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL write_with_start: got %h want %h", obs, mk(4'h9, 1, 0, 1, 0, 0, 0));
        end
        @(posedge clk); #1;
        pulse_abort();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.len = '0; bus.start = 1'b0; bus.abort = 1'b0;
        #3;
        n_chk++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, 13'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_play();
        test_err();
        test_abort();
        test_wr_ignore();
        test_handoff_restart();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
